// File: rtl/data_mem_hs_if.sv
// Request/response channel between the load/store unit (master) and data_mem_hs (slave).
interface data_mem_hs_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [2:0]            req_funct3;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_hs.sv
// Handshaked word-organised data memory: one outstanding RV32 load/store, configurable
// wait states, byte-lane writes, load extension and misaligned/illegal-op detection.
module data_mem_hs #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_SIZE    = 256,
  parameter int WAIT_STATES = 1
) (
  input logic          clk,
  input logic          rst_n,
  data_mem_hs_if.slave bus_if
);
  localparam int IDX_W = $clog2(MEM_SIZE);

  localparam logic [1:0] ST_INIT = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_BUSY = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [2:0]            f3_q, f3_d;
  logic [IDX_W+1:0]      addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic [DATA_WIDTH-1:0] mem [MEM_SIZE];

  logic [IDX_W-1:0]      word_idx;
  logic                  legal, misaligned, access_err, access, do_write;
  logic [3:0]            lane_en;
  logic [DATA_WIDTH-1:0] wr_word, mem_word, shifted, load_data;
  logic [15:0]           half_sel;
  logic [7:0]            byte_sel;

  // Address bits above the word index are intentionally ignored (address wrap).
  logic unused_addr_bits;
  assign unused_addr_bits = ^bus_if.req_addr[ADDR_WIDTH-1:IDX_W+2];

  assign word_idx = addr_q[IDX_W+1:2];

  always_comb begin
    legal = 1'b0;
    case (f3_q)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = !we_q;
      default:                legal = 1'b0;
    endcase
  end

  assign misaligned = ((f3_q[1:0] == 2'b01) && addr_q[0]) ||
                      ((f3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
  assign access_err = !legal || misaligned;
  assign access     = (state_q == ST_BUSY) && (cnt_q == 4'd0);
  assign do_write   = access && we_q && !access_err;

  always_comb begin
    lane_en = 4'b1111;
    wr_word = wdata_q;
    case (f3_q[1:0])
      2'b00: begin
        lane_en = 4'b0001 << addr_q[1:0];
        wr_word = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        lane_en = addr_q[1] ? 4'b1100 : 4'b0011;
        wr_word = {2{wdata_q[15:0]}};
      end
      default: begin
        lane_en = 4'b1111;
        wr_word = wdata_q;
      end
    endcase
  end

  // Storage is deliberately not reset; only byte-enabled writes on the access edge.
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int b = 0; b < 4; b++) begin
        if (lane_en[b]) mem[word_idx][b*8 +: 8] <= wr_word[b*8 +: 8];
      end
    end
  end

  assign mem_word = mem[word_idx];
  assign shifted  = mem_word >> {addr_q[1:0], 3'b000};
  assign byte_sel = shifted[7:0];
  assign half_sel = addr_q[1] ? mem_word[31:16] : mem_word[15:0];

  always_comb begin
    load_data = mem_word;
    case (f3_q)
      3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_data = {24'd0, byte_sel};
      3'b101:  load_data = {16'd0, half_sel};
      default: load_data = mem_word;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_INIT: state_d = ST_IDLE;
      ST_IDLE: begin
        if (bus_if.req_valid) begin
          we_d    = bus_if.req_we;
          f3_d    = bus_if.req_funct3;
          addr_d  = bus_if.req_addr[IDX_W+1:0];
          wdata_d = bus_if.req_wdata;
          cnt_d   = 4'(WAIT_STATES);
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          err_d   = access_err;
          rdata_d = (access_err || we_q) ? '0 : load_data;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus_if.rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign bus_if.req_ready = (state_q == ST_IDLE);
  assign bus_if.rsp_valid = (state_q == ST_RESP);
  assign bus_if.rsp_rdata = rdata_q;
  assign bus_if.rsp_err   = err_q;
endmodule

// File: tb/tb_data_mem_hs.sv
// Self-checking bench for data_mem_hs: directed vector table, reset corner cases and
// randomized traffic checked against a byte-level reference memory.
module tb_data_mem_hs;
  localparam int WS = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  data_mem_hs_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  data_mem_hs #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_SIZE(256), .WAIT_STATES(WS)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus_if(bus)
  );

  typedef struct {
    bit          we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          stall;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] ref_mem [256];
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wd, input int stall,
                              input logic [31:0] rd, input bit err);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wd; v.stall = stall;
    v.exp_rd = rd; v.exp_err = err;
    vecs.push_back(v);
  endfunction

  // Byte-granular reference: sizes, alignment and extension from the RV32 rules.
  function automatic void model(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wd, output logic [31:0] rd, output bit err);
    int idx, off, size;
    logic [31:0] val;
    idx = int'((addr / 4) % 256);
    off = int'(addr % 4);
    case (f3)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      3'd2:       size = 4;
      default:    size = 0;
    endcase
    if (size == 0) err = 1'b1;
    else err = (we && f3 >= 3'd4) || (off % size != 0);
    rd = 32'd0;
    if (err) return;
    if (we) begin
      for (int b = 0; b < size; b++)
        ref_mem[idx] = (ref_mem[idx] & ~(32'hFF << (8 * (off + b)))) |
                       (((wd >> (8 * b)) & 32'hFF) << (8 * (off + b)));
    end else begin
      val = 32'd0;
      for (int b = 0; b < size; b++)
        val = val | (((ref_mem[idx] >> (8 * (off + b))) & 32'hFF) << (8 * b));
      if (f3 < 3'd4 && size < 4 && val[8 * size - 1]) val = val | (32'hFFFFFFFF << (8 * size));
      rd = val;
    end
  endfunction

  task automatic do_txn(input string tag, input bit we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd, input int stall,
                        output logic [31:0] rd, output bit err, output int acc_wait,
                        output int lat);
    bit ready_bad;
    ready_bad = 1'b0;
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
    bus.req_addr = addr; bus.req_wdata = wd;
    acc_wait = 0;
    while (!bus.req_ready && acc_wait < 50) begin
      tick();
      acc_wait++;
    end
    tick();
    bus.req_valid = 1'b0;
    bus.req_addr = $urandom; bus.req_wdata = $urandom; bus.req_funct3 = 3'($urandom);
    lat = 0;
    while (!bus.rsp_valid && lat < 50) begin
      if (bus.req_ready) ready_bad = 1'b1;
      tick();
      lat++;
    end
    rd = bus.rsp_rdata;
    err = bus.rsp_err;
    for (int i = 0; i < stall; i++) begin
      tick();
      chk({tag, " hold_valid"}, 32'(bus.rsp_valid), 32'd1);
      chk({tag, " hold_rdata"}, bus.rsp_rdata, rd);
      chk({tag, " hold_err"}, 32'(bus.rsp_err), 32'(err));
      chk({tag, " hold_ready_low"}, 32'(bus.req_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    #1;
    chk({tag, " ready_low_in_resp"}, 32'(bus.req_ready), 32'd0);
    tick();
    bus.rsp_ready = 1'b0;
    chk({tag, " ready_busy_low"}, 32'(ready_bad), 32'd0);
    chk({tag, " valid_dropped"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, " ready_after_resp"}, 32'(bus.req_ready), 32'd1);
  endtask

  task automatic run_check(input string tag, input bit we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd, input int stall,
                           input logic [31:0] exp_rd, input bit exp_err);
    logic [31:0] rd;
    bit          err;
    int          aw, lat;
    do_txn(tag, we, f3, addr, wd, stall, rd, err, aw, lat);
    $display("txn %s we=%0d f3=%0d addr=0x%08h wd=0x%08h -> rdata=0x%08h err=%0d lat=%0d",
             tag, we, f3, addr, wd, rd, err, lat);
    chk({tag, " accept_wait"}, 32'(aw), 32'd0);
    chk({tag, " latency"}, 32'(lat), 32'(WS + 1));
    chk({tag, " rdata"}, rd, exp_rd);
    chk({tag, " err"}, 32'(err), 32'(exp_err));
  endtask

  initial begin
    logic [31:0] m_rd, wd, addr;
    bit          m_err, we;
    logic [2:0]  f3;

    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'd0;
    bus.req_addr = 32'd0; bus.req_wdata = 32'd0; bus.rsp_ready = 1'b0;

    // Reset held for 3 cycles.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
      chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    end
    rst_n = 1'b1;
    #1;
    chk("init_ready_before_edge", 32'(bus.req_ready), 32'd0);
    tick();
    chk("init_ready_after_edge", 32'(bus.req_ready), 32'd1);

    add(1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 32'h0, 0);
    add(0, 3'b010, 32'h10, 32'h0, 0, 32'hDEADBEEF, 0);
    add(1, 3'b000, 32'h13, 32'h12345680, 0, 32'h0, 0);
    add(0, 3'b000, 32'h13, 32'h0, 0, 32'hFFFFFF80, 0);
    add(0, 3'b100, 32'h13, 32'h0, 0, 32'h00000080, 0);
    add(0, 3'b001, 32'h12, 32'h0, 0, 32'hFFFF80AD, 0);
    add(0, 3'b101, 32'h12, 32'h0, 1, 32'h000080AD, 0);
    add(0, 3'b010, 32'h10, 32'h0, 0, 32'h80ADBEEF, 0);
    add(1, 3'b010, 32'h14, 32'h55667788, 0, 32'h0, 0);
    add(0, 3'b010, 32'h11, 32'h0, 0, 32'h0, 1);
    add(1, 3'b001, 32'h15, 32'h0000FFFF, 0, 32'h0, 1);
    add(0, 3'b011, 32'h14, 32'h0, 0, 32'h0, 1);
    add(1, 3'b100, 32'h14, 32'hFFFFFFFF, 0, 32'h0, 1);
    add(0, 3'b010, 32'h14, 32'h0, 0, 32'h55667788, 0);
    add(1, 3'b001, 32'h16, 32'hABCD1234, 0, 32'h0, 0);
    add(0, 3'b001, 32'h16, 32'h0, 0, 32'h00001234, 0);
    add(0, 3'b010, 32'h14, 32'h0, 0, 32'h12347788, 0);
    add(1, 3'b010, 32'h400, 32'h12345678, 0, 32'h0, 0);
    add(0, 3'b010, 32'h0, 32'h0, 5, 32'h12345678, 0);

    foreach (vecs[i])
      run_check($sformatf("vec%0d", i), vecs[i].we, vecs[i].f3, vecs[i].addr,
                vecs[i].wdata, vecs[i].stall, vecs[i].exp_rd, vecs[i].exp_err);

    // Reset while a store is still counting down: the old word must survive.
    run_check("pre_store", 1, 3'b010, 32'h20, 32'h11111111, 0, 32'h0, 0);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b010;
    bus.req_addr = 32'h20; bus.req_wdata = 32'hAAAAAAAA;
    chk("midrst_ready", 32'(bus.req_ready), 32'd1);
    tick();
    bus.req_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_ready_low", 32'(bus.req_ready), 32'd0);
    chk("midrst_valid_low", 32'(bus.rsp_valid), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("midrst_ready_recover", 32'(bus.req_ready), 32'd1);
    run_check("post_rst_load", 0, 3'b010, 32'h20, 32'h0, 0, 32'h11111111, 0);

    // Random traffic over 16 prefilled words, checked against the reference memory.
    for (int i = 0; i < 16; i++) begin
      wd = $urandom;
      model(1'b1, 3'b010, 32'(i * 4), wd, m_rd, m_err);
      run_check($sformatf("fill%0d", i), 1, 3'b010, 32'(i * 4), wd, 0, m_rd, m_err);
    end
    for (int i = 0; i < 150; i++) begin
      we   = 1'($urandom_range(0, 1));
      f3   = 3'($urandom_range(0, 7));
      addr = (32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3))) |
             (32'($urandom_range(0, 3)) << 10);
      wd   = $urandom;
      model(we, f3, addr, wd, m_rd, m_err);
      run_check($sformatf("rnd%0d", i), we, f3, addr, wd, $urandom_range(0, 2), m_rd, m_err);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/data_mem_hs.md
# data_mem_hs

Handshaked, parametrised successor to the single-cycle data memory. Serves one load/store at a time from the CPU load/store unit over a valid/ready request channel and a valid/ready response channel. Depth and access latency are configurable, and it adds misalignment/illegal-op detection. The storage array is word-organised with byte-lane writes and RV32 load extension (lb/lh/lw/lbu/lhu, sb/sh/sw).

## Interface
- DATA_WIDTH, 32: word width; only 32 is supported.
- ADDR_WIDTH, 32: byte address width.
- MEM_SIZE, 256: depth in words; must be a power of 2, ≥ 2.
- WAIT_STATES, 1: extra access cycles, 0..15.

- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block accepts a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32 load/store funct3.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  store data; low byte/half used for sb/sh.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes the response.
- rsp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and errors.
- rsp_err  out  1  access was misaligned or illegal; no memory effect.

## Operation
- **FSM states:** INIT (reset state), IDLE, BUSY, RESP.
  - INIT → IDLE unconditionally on the first edge after rst_n rises.
- **Request acceptance:** a request is accepted on an edge where req_valid && req_ready. req_ready is 1 only in IDLE.
  - On acceptance, capture we, funct3, addr and wdata.
  - Load cnt = WAIT_STATES and go to BUSY.
- **BUSY:** if cnt != 0, decrement. If cnt == 0, perform the access on that edge, register the result and go to RESP.
- **RESP:** rsp_valid = 1, with rsp_rdata and rsp_err held stable. On an edge with rsp_ready = 1, go to IDLE.
- **Word index:** req_addr[log2(MEM_SIZE)+1:2]. Upper bits are ignored, so addresses wrap modulo 4·MEM_SIZE bytes.
- **Legal loads:** funct3 000 (lb), 001 (lh), 010 (lw), 100 (lbu), 101 (lhu).
- **Legal stores:** funct3 000 (sb), 001 (sh), 010 (sw).
- **Errors:** any other funct3/we combination raises rsp_err = 1.
  - Halfword accesses with addr[0] = 1 raise rsp_err = 1.
  - Word accesses with addr[1:0] != 0 raise rsp_err = 1.
  - On error: no write, rsp_rdata = 0.
- **Stores:** write only the addressed byte lanes (byte lane = addr[1:0], half lane = addr[1]); other lanes are unchanged. Response is rsp_rdata = 0, rsp_err = 0.
- **Loads:** lb/lh sign-extend from the selected lane MSB; lbu/lhu zero-extend; lw returns the full word.
- The array is not reset. Contents are undefined until written.

## Timing
- **Reset values (while rst_n = 0):** state INIT, req_ready 0, rsp_valid 0, rsp_rdata 0, rsp_err 0, cnt 0.
- **Reset mid-transaction:** the transaction is dropped. A store with no access edge yet has no memory effect.
- **Latency:** acceptance at edge k → access at edge k+1+WAIT_STATES → rsp_valid high from then on.
- **Throughput:** with rsp_ready held at 1, back-to-back requests are accepted every WAIT_STATES+3 cycles.
- **Back-pressure:** rsp_valid stays high with stable data for any number of cycles while rsp_ready = 0.
  - req_ready stays 0 during BUSY and RESP.
  - req_valid in those states is ignored, not queued.
- req_ready rises in the cycle after the RESP→IDLE edge. There is no combinational path from rsp_ready to req_ready.
- **Read-after-write:** a load following a store to the same word returns the new data. This is guaranteed because only one transaction is outstanding.

## Test plan
- **Reset and init:** hold rst_n = 0 for 3 cycles, release, then drive req_valid = 1.
  - req_ready = 0 and rsp_valid = 0 during reset.
  - req_ready = 1 one edge after release.
  - First acceptance on the following edge.
- **Word store/load, WAIT_STATES = 1:** sw 0xDEADBEEF to 0x10, then lw 0x10.
  - rsp_valid rises 2 edges after each acceptance.
  - The load returns 0xDEADBEEF with rsp_err = 0.
- **Byte lanes and extension:** sb 0x80 to 0x13, then lb 0x13, lbu 0x13, lh 0x12 and lw 0x10.
  - lb 0x13 → 0xFFFFFF80.
  - lbu 0x13 → 0x00000080.
  - lh 0x12 → 0xFFFF80AD.
  - lw 0x10 → 0x80ADBEEF.
- **Errors:** lw 0x11, sh 0x15, funct3 = 011 load.
  - Each gives rsp_err = 1 and rsp_rdata = 0.
  - Subsequent lw 0x14 shows the word unchanged.
- **Back-pressure and wrap:** with MEM_SIZE = 256, sw 0x12345678 to 0x400, then lw 0x0 with rsp_ready held 0 for 5 cycles.
  - rsp_valid holds 0x12345678, stable, for all 5 cycles.
  - req_ready stays 0 until the cycle after rsp_ready is asserted.
- **Reset mid-store:** with WAIT_STATES = 3, sw 0xAAAAAAAA to 0x20 after first storing 0x11111111 there; pulse rst_n low during BUSY.
  - After recovery, lw 0x20 returns 0x11111111.
